// File: rtl/r5fp_round_pack.sv
// Rounds and packs an unrounded R5FP tuple {sign, exp, status, sig+GR, sticky} into an IEEE result plus fflags.
// Latency 1 (specials), 2 (normal), 2+shift (subnormal); in_ready only in IDLE, result held until out_ready.
module r5fp_round_pack #(
   parameter int EXP_W = 5,
   parameter int SIG_W = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+1:0]       in_exp,
   input  logic [SIG_W+3:0]       in_sig,
   input  logic                   in_sign,
   input  logic [5:0]             in_status,
   input  logic [2:0]             rnd,
   input  logic                   kill,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+SIG_W:0]   out_z,
   output logic [4:0]             out_flags
);
   localparam int EW = EXP_W + 2;
   localparam int SW = SIG_W + 4;
   localparam int ZW = EXP_W + SIG_W + 1;
   localparam int CW = $clog2(SW);
   localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] SH_MAX  = EW'(SIG_W + 3);
   localparam logic signed [EW-1:0] ONE     = EW'(1);
   localparam logic signed [EW-1:0] ZERO    = '0;
   localparam int ST_STICKY = 0;
   localparam int ST_SIGN   = 1;
   localparam int ST_ZERO   = 2;
   localparam int ST_INF    = 3;
   localparam int ST_NAN    = 4;
   localparam int ST_INV    = 5;

   typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

   function automatic logic rnd_inc(input logic [2:0] mode, input logic sgn, input logic lsb,
                                    input logic g, input logic rs);
      logic inc;
      case (mode)
         3'd0:    inc = g & (rs | lsb);
         3'd2:    inc = sgn & (g | rs);
         3'd3:    inc = ~sgn & (g | rs);
         3'd4:    inc = g;
         default: inc = 1'b0;
      endcase
      return inc;
   endfunction

   state_t               state_q, state_d;
   logic                 sign_q, sign_d, sticky_q, sticky_d, inv_q, inv_d, tiny_q, tiny_d;
   logic signed [EW-1:0] exp_q, exp_d;
   logic [SW-1:0]        sig_q, sig_d;
   logic [2:0]           rnd_q, rnd_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [ZW-1:0]        out_z_q, out_z_d;
   logic [4:0]           out_flags_q, out_flags_d;

   logic signed [EW-1:0] in_exp_s, shamt, exp_r;
   logic [SIG_W+1:0]     rounded;
   logic                 carry, inexact, ovf, inc_full, keep_max, is_special;
   logic [EXP_W-1:0]     exp_ones;

   assign exp_ones   = '1;
   assign in_exp_s   = in_exp;
   assign shamt      = ONE - in_exp_s;
   assign is_special = in_status[ST_NAN] | in_status[ST_INF] | in_status[ST_ZERO];
   // Full-precision rounding of the raw input decides tininess at in_exp == 0.
   assign inc_full   = rnd_inc(rnd, in_sign, in_sig[2], in_sig[1], in_sig[0] | in_status[ST_STICKY]);

   assign inexact  = sig_q[1] | sig_q[0] | sticky_q;
   assign rounded  = sig_q[SW-1:2]
                   + {{(SIG_W+1){1'b0}}, rnd_inc(rnd_q, sign_q, sig_q[2], sig_q[1], sig_q[0] | sticky_q)};
   assign carry    = (exp_q == ZERO) ? rounded[SIG_W] : rounded[SIG_W+1];
   assign exp_r    = exp_q + {{(EW-1){1'b0}}, carry};
   // Overflow is judged on the value rounded to nearest as well, so truncating modes still flag OF.
   assign ovf      = (exp_r >= EXP_MAX) || ((exp_q == EXP_MAX - ONE) && sig_q[1] && (&sig_q[SW-3:2]));
   assign keep_max = (rnd_q == 3'd1) | ((rnd_q == 3'd2) & ~sign_q) | ((rnd_q == 3'd3) & sign_q);

   always_comb begin
      state_d     = state_q;
      sign_d      = sign_q;
      sticky_d    = sticky_q;
      inv_d       = inv_q;
      tiny_d      = tiny_q;
      exp_d       = exp_q;
      sig_d       = sig_q;
      rnd_d       = rnd_q;
      cnt_d       = cnt_q;
      out_z_d     = out_z_q;
      out_flags_d = out_flags_q;
      if (kill) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               sign_d   = in_sign;
               exp_d    = in_exp_s;
               sig_d    = in_sig;
               sticky_d = in_status[ST_STICKY];
               rnd_d    = rnd;
               inv_d    = in_status[ST_INV];
               tiny_d   = (in_exp_s < ZERO) || ((in_exp_s == ZERO) && !((&in_sig[SW-3:2]) && inc_full));
               cnt_d    = (shamt > SH_MAX) ? SH_MAX[CW-1:0] : shamt[CW-1:0];
               if (is_special) begin
                  state_d     = DONE;
                  out_flags_d = {in_status[ST_INV], 4'b0000};
                  if (in_status[ST_NAN])
                     out_z_d = {1'b0, exp_ones, 1'b1, {(SIG_W-1){1'b0}}};
                  else if (in_status[ST_INF])
                     out_z_d = {in_status[ST_SIGN], exp_ones, {SIG_W{1'b0}}};
                  else
                     out_z_d = {in_sign, {(ZW-1){1'b0}}};
               end else if (in_exp_s <= ZERO) begin
                  state_d = SHIFT;
               end else begin
                  state_d = ROUND;
               end
            end
            SHIFT: begin
               sig_d    = sig_q >> 1;
               sticky_d = sticky_q | sig_q[0];
               cnt_d    = cnt_q - 1'b1;
               if (cnt_q == CW'(1)) begin
                  state_d = ROUND;
                  exp_d   = ZERO;
               end
            end
            ROUND: begin
               state_d     = DONE;
               out_flags_d = {inv_q, 1'b0, ovf, (inexact | ovf) & tiny_q, inexact | ovf};
               if (ovf && keep_max)
                  out_z_d = {sign_q, exp_ones - 1'b1, {SIG_W{1'b1}}};
               else if (ovf)
                  out_z_d = {sign_q, exp_ones, {SIG_W{1'b0}}};
               else
                  out_z_d = {sign_q, exp_r[EXP_W-1:0], rounded[SIG_W-1:0]};
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sign_q      <= 1'b0;
         sticky_q    <= 1'b0;
         inv_q       <= 1'b0;
         tiny_q      <= 1'b0;
         exp_q       <= '0;
         sig_q       <= '0;
         rnd_q       <= '0;
         cnt_q       <= '0;
         out_z_q     <= '0;
         out_flags_q <= '0;
      end else begin
         state_q     <= state_d;
         sign_q      <= sign_d;
         sticky_q    <= sticky_d;
         inv_q       <= inv_d;
         tiny_q      <= tiny_d;
         exp_q       <= exp_d;
         sig_q       <= sig_d;
         rnd_q       <= rnd_d;
         cnt_q       <= cnt_d;
         out_z_q     <= out_z_d;
         out_flags_q <= out_flags_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_z     = out_z_q;
   assign out_flags = out_flags_q;

endmodule

// File: tb/tb_r5fp_round_pack.sv
// Bench for r5fp_round_pack: directed corner cases, reset/kill, then random tuples vs a value-level rounding model.
module tb_r5fp_round_pack;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_exp;
   logic [13:0] in_sig;
   logic        in_sign;
   logic [5:0]  in_status;
   logic [2:0]  rnd;
   logic        kill;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_z;
   logic [4:0]  out_flags;

   int n_tests = 0;
   int n_fail  = 0;

   r5fp_round_pack dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_exp(in_exp), .in_sig(in_sig), .in_sign(in_sign), .in_status(in_status),
      .rnd(rnd), .kill(kill), .out_valid(out_valid), .out_ready(out_ready),
      .out_z(out_z), .out_flags(out_flags)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Round m (with extra sticky s) by discarding k low bits, value-level comparison against half an ulp.
   function automatic longint round_at(input longint m, input bit s, input int k, input int mode, input bit sgn);
      longint q, rem, half;
      bit above, tie, any, up;
      q     = m >> k;
      rem   = m - (q << k);
      half  = longint'(1) << (k - 1);
      above = (rem > half) || (rem == half && s);
      tie   = (rem == half) && !s;
      any   = (rem != 0) || s;
      case (mode)
         0:       up = above || (tie && (q % 2 == 1));
         2:       up = sgn && any;
         3:       up = !sgn && any;
         4:       up = (rem >= half);
         default: up = 1'b0;
      endcase
      return q + longint'(up);
   endfunction

   task automatic ref_model(input int e, input int frac, input bit g, input bit r, input bit sgn,
                            input int mode, input logic [5:0] st,
                            output logic [15:0] z, output logic [4:0] fl, output int lat);
      longint m, q, qn, mag, magn;
      int k;
      bit exact, of, nx, tiny, maxf;
      fl  = {st[5], 4'b0000};
      lat = 1;
      if (st[4])      z = 16'h7E00;
      else if (st[3]) z = {st[1], 15'h7C00};
      else if (st[2]) z = {sgn, 15'h0000};
      else begin
         m     = longint'((1024 + frac) * 4 + int'(g) * 2 + int'(r));
         k     = (e < 1) ? 3 - e : 2;
         q     = round_at(m, st[0], k, mode, sgn);
         qn    = round_at(m, st[0], k, 4, sgn);
         mag   = (e >= 1) ? longint'(e) * 1024 + q - 1024 : q;
         magn  = (e >= 1) ? longint'(e) * 1024 + qn - 1024 : qn;
         exact = ((m % (longint'(1) << k)) == 0) && !st[0];
         of    = (e >= 1) && (mag >= 31744 || magn >= 31744);
         nx    = !exact || of;
         tiny  = (e < 0) || (e == 0 && round_at(m, st[0], 2, mode, sgn) < 2048);
         maxf  = (mode == 1) || (mode == 2 && !sgn) || (mode == 3 && sgn);
         if (of) z = {sgn, maxf ? 15'h7BFF : 15'h7C00};
         else    z = {sgn, mag[14:0]};
         fl  = {st[5], 1'b0, of, nx && tiny, nx};
         lat = (e >= 1) ? 2 : 2 + (((1 - e) < 13) ? (1 - e) : 13);
      end
   endtask

   task automatic drive(input int e, input int frac, input bit g, input bit r, input bit sgn,
                        input int mode, input logic [5:0] st);
      in_exp    = e[6:0];
      in_sig    = {2'b01, frac[9:0], g, r};
      in_sign   = sgn;
      in_status = st;
      rnd       = mode[2:0];
   endtask

   task automatic scramble();
      in_exp    = 7'($urandom);
      in_sig    = 14'($urandom);
      in_sign   = 1'($urandom);
      in_status = 6'($urandom);
      rnd       = 3'($urandom);
   endtask

   // Called and returns at a negedge with the DUT idle.
   task automatic run_txn(input int e, input int frac, input bit g, input bit r, input bit sgn,
                          input int mode, input logic [5:0] st, input int hold);
      logic [15:0] ez, z0;
      logic [4:0]  ef;
      int          elat, lat;
      ref_model(e, frac, g, r, sgn, mode, st, ez, ef, elat);
      check("in_ready_idle", 32'(in_ready), 32'd1);
      drive(e, frac, g, r, sgn, mode, st);
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         if (lat == 0) begin
            in_valid = 1'b0;
            scramble();
         end
         lat++;
      end while (!out_valid && lat < 40);
      check("latency", 32'(lat), 32'(elat));
      check("out_z", 32'(out_z), 32'(ez));
      check("out_flags", 32'(out_flags), 32'(ef));
      z0 = out_z;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_z", 32'(out_z), 32'(z0));
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("handshake_clears", 32'(out_valid), 32'd0);
   endtask

   initial begin
      int e, frac, mode, hold, sel;
      bit g, r, s, sgn, inv;
      logic [5:0] st;

      rst_n = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1;
      drive(0, 0, 1'b0, 1'b0, 1'b0, 0, 6'd0);
      repeat (3) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_z", 32'(out_z), 32'd0);
      check("rst_out_flags", 32'(out_flags), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Directed corners: {INV, NAN, INF, ZERO, SIGN, STICKY}
      run_txn(15, 10'h001, 1, 0, 0, 0, 6'b000000, 0);   // tie to even -> 0x3C02
      run_txn(30, 10'h3FF, 1, 0, 0, 0, 6'b000000, 0);   // overflow RNE -> 0x7C00
      run_txn(30, 10'h3FF, 1, 0, 0, 1, 6'b000000, 0);   // overflow RTZ -> 0x7BFF
      run_txn(-2, 10'h000, 0, 0, 0, 0, 6'b000000, 0);   // exact subnormal -> 0x0080
      run_txn(-20, 10'h000, 0, 0, 0, 3, 6'b000000, 0);  // deep underflow RUP -> 0x0001
      run_txn(-20, 10'h000, 0, 0, 0, 0, 6'b000000, 0);  // deep underflow RNE -> 0x0000
      run_txn(3, 10'h000, 0, 0, 0, 0, 6'b110000, 4);    // NaN+INV, backpressure
      run_txn(0, 10'h3FF, 1, 0, 0, 0, 6'b000000, 0);    // rounds up to 2^emin, not tiny
      run_txn(5, 10'h155, 0, 0, 1, 0, 6'b001010, 0);    // -Inf
      run_txn(5, 10'h155, 0, 0, 1, 0, 6'b000100, 1);    // -0
      run_txn(30, 10'h3FF, 1, 1, 1, 2, 6'b000001, 0);   // RDN negative overflow -> -Inf
      run_txn(12, 10'h2A0, 1, 0, 1, 4, 6'b100000, 0);   // RMM tie, NV passthrough

      // Reset while shifting
      drive(-20, 10'h123, 1'b1, 1'b0, 1'b0, 0, 6'd0);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("shift_in_ready", 32'(in_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("midshift_rst_valid", 32'(out_valid), 32'd0);
      check("midshift_rst_z", 32'(out_z), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Kill during ROUND
      drive(15, 10'h001, 1'b1, 1'b0, 1'b0, 0, 6'd0);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      kill     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      kill = 1'b0;
      check("kill_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("kill_no_valid", 32'(out_valid), 32'd0);
      end
      run_txn(16, 10'h0FF, 1, 1, 0, 0, 6'b000000, 0);

      // Kill in IDLE blocks accept
      drive(15, 10'h001, 1'b1, 1'b0, 1'b0, 0, 6'd0);
      in_valid = 1'b1;
      kill     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      kill     = 1'b0;
      check("kill_idle_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("kill_idle_no_valid", 32'(out_valid), 32'd0);

      // Random tuples
      for (int n = 0; n < 250; n++) begin
         sel = $urandom_range(0, 3);
         case (sel)
            0:       e = -int'($urandom_range(0, 22));
            1:       e = int'($urandom_range(1, 29));
            2:       e = int'($urandom_range(29, 35));
            default: e = int'($urandom_range(0, 4)) - 2;
         endcase
         frac = ($urandom_range(0, 3) == 0) ? 1023 : int'($urandom_range(0, 1023));
         g    = 1'($urandom);
         r    = 1'($urandom);
         s    = 1'($urandom);
         sgn  = 1'($urandom);
         inv  = ($urandom_range(0, 7) == 0);
         mode = int'($urandom_range(0, 4));
         st   = {inv, 3'b000, 1'($urandom), s};
         if ($urandom_range(0, 7) == 0) st[4:2] = 3'($urandom_range(1, 7));
         hold = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
         run_txn(e, frac, g, r, sgn, mode, st, hold);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/r5fp_round_pack.md
Name: r5fp_round_pack

Overview:
- Sequential back end for the R5FP unrounded-result datapath.
- Accepts an unrounded {sign, exponent, status, significand-with-guard/round, sticky} tuple, as produced by the add/mul/acc cores.
- Denormalises iteratively, rounds per the RISC-V mode, and packs an IEEE result plus fflags.
- Sits between the arithmetic cores and the FPU writeback; uses a valid/ready handshake on both sides.

Parameters:
- EXP_W, 5, exponent width of the packed result.
- SIG_W, 10, stored fraction width of the packed result.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input tuple valid
- in_ready  output  1  block can accept (high only in IDLE)
- in_exp  input  EXP_W+2  signed biased exponent; value = 1.frac * 2^(in_exp - bias), bias = 2^(EXP_W-1)-1
- in_sig  input  SIG_W+4  {2'b01, frac[SIG_W-1:0], G, R}
- in_sign  input  1  result sign for finite/zero results
- in_status  input  6  status bits per R5FP_inc.vh macros (INVALID, IS_NAN, IS_INF, IS_ZERO, SIGN, STICKY)
- rnd  input  3  0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; sampled with input
- kill  input  1  synchronous abort, returns to IDLE
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_z  output  EXP_W+SIG_W+1  packed {sign, exp, frac}
- out_flags  output  5  {NV, DZ(=0), OF, UF, NX}

Behaviour:
- Reset (async, rst_n low): state IDLE, out_valid=0, out_z=0, out_flags=0, all internal registers 0. in_ready=1 after release.
- States: IDLE, SHIFT, ROUND, DONE.
- IDLE: on in_valid&in_ready, register all inputs.
  - If NaN/Inf/zero status is set, go to DONE (1-cycle latency).
  - Else if in_exp<=0, go to SHIFT with cnt=min(1-in_exp, SIG_W+3).
  - Else go to ROUND.
- SHIFT: each cycle, shift the significand right 1 bit and OR the bit shifted out into sticky; decrement cnt.
  - At cnt==1, go to ROUND and set exponent field to 0.
  - Latency grows by cnt cycles.
- ROUND: compute the increment from LSB, G, (R|sticky), sign and rnd.
  - RNE: G&(R|S|LSB).
  - RMM: G.
  - RUP: !sign&(G|R|S).
  - RDN: sign&(G|R|S).
  - RTZ: 0.
  - Fraction carry-out increments the exponent; a subnormal carrying into bit SIG_W becomes exponent 1.
  - Go to DONE. Normal-path latency is 2 cycles from accept to out_valid.
- Overflow: if rounded exp >= 2^EXP_W-1, set OF|NX.
  - Result is max-finite (exp=2^EXP_W-2, frac all ones) for RTZ, RDN&!sign, RUP&sign.
  - Otherwise result is Inf.
- NX = G|R|sticky (after denormal shifting) or overflow.
- UF = NX & tiny. Tiny is evaluated after rounding: in_exp<0, or in_exp==0 and rounding at full precision does not carry to 2^emin.
- Specials:
  - IS_NAN: canonical NaN, sign 0, exp all ones, frac MSB 1, remaining bits 0.
  - IS_INF: exp all ones, frac 0, sign = status SIGN.
  - IS_ZERO: all-zero magnitude, sign = in_sign.
  - NV = status INVALID for all cases. Specials never set OF/UF/NX.
- DONE: out_valid=1 and out_z/out_flags are held stable until out_ready; on handshake go to IDLE.
  - in_ready stays low until the state is IDLE again, so there is no back-to-back accept in the same cycle as out handshake.
  - Throughput is one result per (latency+1) cycles minimum.
- kill: in any state, next state is IDLE and out_valid is 0 next cycle; an in-flight result is dropped. kill has priority over handshakes. kill in IDLE blocks accept that cycle.
- rnd, sign and status are used only from the registered copy; input changes after accept have no effect.
- Exponent arithmetic is signed EXP_W+2 bits; no wrap occurs for in_exp in [-(2^EXP_W), 2^EXP_W+3].

Test Plan:
- Tie to even:
  - Stimulus: in_exp=15, frac=0x001, G=1, R=0, S=0, RNE.
  - Required: out_z=0x3C02, flags=5'b00001; out_valid 2 cycles after accept.
- Overflow:
  - Stimulus: in_exp=30, frac=0x3FF, G=1, RNE.
  - Required: out_z=0x7C00, flags=5'b00101.
  - Same input with RTZ: out_z=0x7BFF, flags=5'b00101.
- Exact subnormal:
  - Stimulus: in_exp=-2, frac=0, GRS=0.
  - Required: 3 SHIFT cycles, out_z=0x0080, flags=0; out_valid 5 cycles after accept.
- Deep underflow:
  - Stimulus: in_exp=-20, positive, RUP.
  - Required: SHIFT saturates at 13 cycles, out_z=0x0001, flags=5'b00011.
  - Same input with RNE: out_z=0x0000, flags=5'b00011.
- Specials and backpressure:
  - IS_NAN with INVALID -> out_z=0x7E00, flags=5'b10000, latency 1.
  - Hold out_ready=0 for 4 cycles -> out_z stable, in_ready=0 throughout; next accept is possible 1 cycle after the handshake.
- Reset and kill:
  - Assert rst_n=0 mid-SHIFT -> out_valid=0 immediately; in_ready=1 after release.
  - Assert kill during ROUND -> no out_valid; the next input is processed correctly.
